alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 132 +++++++++++++
 tb/tb_alu_exec_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - multi-cycle ALU execute stage with bit-serial shifter and valid/ready handshake
//
// Purpose: accepts one operation at a time, computes it (single cycle for
// logic/arith/pass ops, one bit per cycle for shifts), and holds the result
// until the consumer takes it.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   In_valid   operation presented upstream
//   In_ready   block can accept an operation (IDLE)
//   Op         0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SRA, 6 SLL, 7 PASSB
//   SrcA       operand A
//   SrcB       operand B; SrcB[4:0] is the shift amount
//   Result     registered result
//   Zero       Result == 0, meaningful while Out_valid
//   Out_valid  Result/Zero valid (DONE)
//   Out_ready  consumer takes the result
//   Busy       not IDLE
module alu_exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            In_valid,
    output logic            In_ready,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            Out_valid,
    input  logic            Out_ready,
    output logic            Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SRA   = 3'd5;
    localparam logic [2:0] OP_SLL   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    state_t            r_state;
    logic [XLEN-1:0]   r_result;   // doubles as the shifter working register
    logic [4:0]        r_count;
    logic              r_is_sra;

    state_t            w_state_nxt;
    logic [XLEN-1:0]   w_result_nxt;
    logic [4:0]        w_count_nxt;
    logic              w_is_sra_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_count  <= '0;
            r_is_sra <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_count  <= w_count_nxt;
            r_is_sra <= w_is_sra_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_count_nxt  = r_count;
        w_is_sra_nxt = r_is_sra;
        case (r_state)
            IDLE: begin
                if (In_valid) begin
                    w_state_nxt = DONE;
                    case (Op)
                        OP_ADD:   w_result_nxt = SrcA + SrcB;
                        OP_SUB:   w_result_nxt = SrcA - SrcB;
                        OP_AND:   w_result_nxt = SrcA & SrcB;
                        OP_OR:    w_result_nxt = SrcA | SrcB;
                        OP_XOR:   w_result_nxt = SrcA ^ SrcB;
                        OP_PASSB: w_result_nxt = SrcB;
                        OP_SRA, OP_SLL: begin
                            w_result_nxt = SrcA;
                            w_count_nxt  = SrcB[4:0];
                            w_is_sra_nxt = (Op == OP_SRA);
                            // Zero shift amount skips SHIFT entirely.
                            if (SrcB[4:0] != 5'd0) begin
                                w_state_nxt = SHIFT;
                            end
                        end
                        default:  w_result_nxt = SrcB;
                    endcase
                end
            end
            SHIFT: begin
                if (r_is_sra) begin
                    w_result_nxt = {r_result[XLEN-1], r_result[XLEN-1:1]};
                end else begin
                    w_result_nxt = {r_result[XLEN-2:0], 1'b0};
                end
                w_count_nxt = r_count - 5'd1;
                // The last shift is taken on the same edge that enters DONE.
                if (r_count == 5'd1) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (Out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign In_ready  = (r_state == IDLE);
    assign Out_valid = (r_state == DONE);
    assign Busy      = (r_state != IDLE);
    assign Result    = r_result;
    assign Zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            In_valid = 1'b0;
    logic            In_ready;
    logic [2:0]      Op = 3'd0;
    logic [XLEN-1:0] SrcA = '0;
    logic [XLEN-1:0] SrcB = '0;
    logic [XLEN-1:0] Result;
    logic            Zero;
    logic            Out_valid;
    logic            Out_ready = 1'b0;
    logic            Busy;

    alu_exec_stage #(.XLEN(XLEN)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Op        (Op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Result    (Result),
        .Zero      (Zero),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return $unsigned($signed(a) >>> b[4:0]);
            3'd6: return a << b[4:0];
            default: return b;
        endcase
    endfunction

    // Transaction-level model: one pending op, its final value and its remaining latency.
    bit          m_busy  = 0;
    bit          m_valid = 0;
    int          m_lat   = 0;
    logic [31:0] m_res   = '0;
    bit          run_cmp = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_busy = 0; m_valid = 0; m_lat = 0;
        end else if (!m_busy) begin
            if (In_valid) begin
                m_busy  = 1;
                m_res   = ref_op(Op, SrcA, SrcB);
                m_lat   = (Op == 3'd5 || Op == 3'd6) ? int'(SrcB[4:0]) : 0;
                m_valid = (m_lat == 0);
            end
        end else if (!m_valid) begin
            m_lat--;
            if (m_lat == 0) m_valid = 1;
        end else if (Out_ready) begin
            m_busy = 0; m_valid = 0;
        end
    end

    always @(negedge CLK) begin
        if (run_cmp) begin
            chk("model_in_ready", 32'(In_ready), 32'(!m_busy));
            chk("model_busy", 32'(Busy), 32'(m_busy));
            chk("model_out_valid", 32'(Out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_result", Result, m_res);
                chk("model_zero", 32'(Zero), 32'(m_res == 32'd0));
            end
        end
    end

    // Called at a negedge; returns at the negedge one cycle after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (!In_ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("issue_ready_timeout", 32'(In_ready), 32'd1);
        In_valid = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(negedge CLK);
        In_valid = 1'b0; Op = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int shiftc;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_result", Result, 32'd0);
        chk("reset_out_valid", 32'(Out_valid), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        RST = 1'b0;
        run_cmp = 1;
        @(negedge CLK);
        chk("post_reset_in_ready", 32'(In_ready), 32'd1);

        // ADD wraps to zero.
        Out_ready = 1'b1;
        issue(3'd0, 32'hFFFF_FFFF, 32'd1);
        chk("add_out_valid", 32'(Out_valid), 32'd1);
        chk("add_result", Result, 32'h0000_0000);
        chk("add_zero", 32'(Zero), 32'd1);
        @(negedge CLK);
        chk("add_back_idle", 32'(In_ready), 32'd1);

        // SRA by 4: four SHIFT cycles, valid on the fifth.
        Out_ready = 1'b0;
        issue(3'd5, 32'h8000_0000, 32'd4);
        lat = 1; shiftc = 0;
        while (!Out_valid && lat < 100) begin
            if (Busy) shiftc++;
            @(negedge CLK);
            lat++;
        end
        chk("sra_latency", 32'(lat), 32'd5);
        chk("sra_shift_cycles", 32'(shiftc), 32'd4);
        chk("sra_result", Result, 32'hF800_0000);
        Out_ready = 1'b1;
        @(negedge CLK);

        // SLL with SrcB=0x20 has shamt 0.
        issue(3'd6, 32'h1234_5678, 32'h0000_0020);
        chk("sll0_out_valid", 32'(Out_valid), 32'd1);
        chk("sll0_result", Result, 32'h1234_5678);
        @(negedge CLK);

        // Backpressure on SUB, with new requests offered during DONE and at the handoff edge.
        Out_ready = 1'b0;
        issue(3'd1, 32'd5, 32'd7);
        In_valid = 1'b1; Op = 3'd7; SrcB = 32'h0000_AAAA;
        for (int k = 0; k < 3; k++) begin
            chk("bp_out_valid", 32'(Out_valid), 32'd1);
            chk("bp_result", Result, 32'hFFFF_FFFE);
            chk("bp_in_ready", 32'(In_ready), 32'd0);
            if (k == 2) Out_ready = 1'b1;
            @(negedge CLK);
        end
        chk("bp_idle_after", 32'(In_ready), 32'd1);
        chk("bp_not_busy", 32'(Busy), 32'd0);
        In_valid = 1'b0;

        // Reset during the 10th shift cycle of SLL by 31.
        issue(3'd6, 32'd1, 32'd31);
        for (int j = 1; j < 10; j++) begin
            chk("rst_shift_no_valid", 32'(Out_valid), 32'd0);
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_mid_in_ready", 32'(In_ready), 32'd1);
        chk("rst_mid_result", Result, 32'd0);
        chk("rst_mid_out_valid", 32'(Out_valid), 32'd0);
        @(negedge CLK);
        chk("rst_mid_no_valid_later", 32'(Out_valid), 32'd0);

        // New request during SHIFT is ignored; PASSB queued afterwards.
        Out_ready = 1'b0;
        issue(3'd6, 32'd3, 32'd3);
        In_valid = 1'b1; Op = 3'd7; SrcB = 32'h0000_DEAD;
        @(negedge CLK);
        In_valid = 1'b0;
        lat = 0;
        while (!Out_valid && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        chk("busy_ignore_result", Result, 32'h0000_0018);
        Out_ready = 1'b1;
        @(negedge CLK);
        issue(3'd7, 32'h0, 32'h0001_2000);
        chk("passb_out_valid", 32'(Out_valid), 32'd1);
        chk("passb_result", Result, 32'h0001_2000);
        @(negedge CLK);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 1500; i++) begin
            RST       = ($urandom_range(0, 99) == 0);
            In_valid  = 1'($urandom);
            Op        = 3'($urandom);
            SrcA      = $urandom;
            SrcB      = ($urandom_range(0, 3) == 0) ? -SrcA : $urandom;
            Out_ready = 1'($urandom);
            @(negedge CLK);
        end
        RST = 1'b0; In_valid = 1'b0; Out_ready = 1'b1;
        repeat (40) @(negedge CLK);
        chk("final_idle", 32'(In_ready), 32'd1);

        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
